pulse_stretch_mc: RTL and testbench

- Multi-channel pulse stretcher with a runtime length per channel and a selectable retrigger policy.
- Replaces the fixed-width single-channel pulse_stretch.
- Each channel turns a short trigger on its input bit into an output held high for exactly len[ch] clock cycles.
- Also reports stretch completion (done) and ignored triggers (miss).
- Sits between event sources (edge detectors, status strobes) and slow consumers such as LEDs, interrupt lines and cross-domain synchronisers.

---
 rtl/pulse_stretch_mc_pkg.sv | 9 +
 rtl/pulse_stretch_mc_if.sv | 27 ++
 rtl/pulse_stretch_mc_ch.sv | 68 ++++++
 rtl/pulse_stretch_mc.sv | 41 ++++
 tb/tb_pulse_stretch_mc.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_stretch_mc_pkg.sv
// Shared constants for the multi-channel pulse stretcher: default counter
// width and the longest stretch that width can express.
package pulse_stretch_pkg;

  localparam int DEF_LEN_W = 8;

  localparam logic [DEF_LEN_W-1:0] MAX_LEN = DEF_LEN_W'(2**DEF_LEN_W-1);

endpackage

// File: rtl/pulse_stretch_mc_if.sv
// Trigger/length/result bundle between an event source and the stretcher.
// The source drives ena/in/len; the stretcher returns out/done/miss.
interface pulse_stretch_mc_if
  import pulse_stretch_pkg::*;
#(
  parameter int CH    = 8,
  parameter int LEN_W = DEF_LEN_W
);

  logic                ena;
  logic [CH-1:0]       in;
  logic [CH*LEN_W-1:0] len;
  logic [CH-1:0]       out;
  logic [CH-1:0]       done;
  logic [CH-1:0]       miss;

  modport master (
    output ena, in, len,
    input  out, done, miss
  );

  modport slave (
    input  ena, in, len,
    output out, done, miss
  );

endinterface

// File: rtl/pulse_stretch_mc_ch.sv
// One stretcher channel: edge history, down-counter and registered
// out/done/miss flags. Length is captured only when a trigger is accepted.
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int LEN_W     = DEF_LEN_W,
  parameter int RETRIG    = 1,
  parameter int EDGE_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic             in_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             out_o,
  output logic             done_o,
  output logic             miss_o
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic             inPrev_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             miss_q, miss_d;
  logic             trig, busy, accept;

  // A trigger in the final cycle (cnt == 1) is always taken so back-to-back
  // stretches join without a gap; only cnt > 1 counts as busy.
  always_comb begin
    trig   = ena_i & ((EDGE_MODE != 0) ? (in_i & ~inPrev_q) : in_i);
    busy   = (cnt_q > ONE);
    accept = trig & ((RETRIG != 0) | ~busy);

    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = len_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end

    out_d  = (cnt_d != '0);
    done_d = ~accept & (cnt_q == ONE);
    miss_d = trig & ~accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inPrev_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      done_q   <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      inPrev_q <= in_i;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      done_q   <= done_d;
      miss_q   <= miss_d;
    end
  end

  assign out_o  = out_q;
  assign done_o = done_q;
  assign miss_o = miss_q;

endmodule

// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher: CH independent channels, each with its own
// runtime length slice and a shared retrigger policy and trigger mode.
module pulse_stretch_mc
  import pulse_stretch_pkg::*;
#(
  parameter int CH        = 8,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int RETRIG    = 1,
  parameter int EDGE_MODE = 1
) (
  input  logic               clk,
  input  logic               rst,
  pulse_stretch_mc_if.slave  ps
);

  logic [CH-1:0] outVec;
  logic [CH-1:0] doneVec;
  logic [CH-1:0] missVec;

  for (genvar g = 0; g < CH; g++) begin : gCh
    pulse_stretch_ch #(
      .LEN_W     (LEN_W),
      .RETRIG    (RETRIG),
      .EDGE_MODE (EDGE_MODE)
    ) uCh (
      .clk    (clk),
      .rst    (rst),
      .ena_i  (ps.ena),
      .in_i   (ps.in[g]),
      .len_i  (ps.len[g*LEN_W +: LEN_W]),
      .out_o  (outVec[g]),
      .done_o (doneVec[g]),
      .miss_o (missVec[g])
    );
  end

  assign ps.out  = outVec;
  assign ps.done = doneVec;
  assign ps.miss = missVec;

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Bench for pulse_stretch_mc: four instances cover every RETRIG/EDGE_MODE
// pairing; a vector table plus two long hand sequences feed a scoreboard.
module tb_pulse_stretch_mc;
  import pulse_stretch_pkg::*;

  localparam int NCH  = 4;
  localparam int LW   = DEF_LEN_W;
  localparam int NCYC = 20;
  localparam int NVEC = 13;

  logic clk;
  logic rst;

  // Instance index: 0 = retrig/edge, 1 = no-retrig/edge,
  // 2 = retrig/level, 3 = no-retrig/level.
  pulse_stretch_mc_if #(.CH(NCH), .LEN_W(LW)) ifA ();
  pulse_stretch_mc_if #(.CH(NCH), .LEN_W(LW)) ifB ();
  pulse_stretch_mc_if #(.CH(NCH), .LEN_W(LW)) ifC ();
  pulse_stretch_mc_if #(.CH(NCH), .LEN_W(LW)) ifD ();

  pulse_stretch_mc #(.CH(NCH), .LEN_W(LW), .RETRIG(1), .EDGE_MODE(1))
    dutA (.clk(clk), .rst(rst), .ps(ifA.slave));
  pulse_stretch_mc #(.CH(NCH), .LEN_W(LW), .RETRIG(0), .EDGE_MODE(1))
    dutB (.clk(clk), .rst(rst), .ps(ifB.slave));
  pulse_stretch_mc #(.CH(NCH), .LEN_W(LW), .RETRIG(1), .EDGE_MODE(0))
    dutC (.clk(clk), .rst(rst), .ps(ifC.slave));
  pulse_stretch_mc #(.CH(NCH), .LEN_W(LW), .RETRIG(0), .EDGE_MODE(0))
    dutD (.clk(clk), .rst(rst), .ps(ifD.slave));

  logic [NCH-1:0] outV  [4];
  logic [NCH-1:0] doneV [4];
  logic [NCH-1:0] missV [4];

  assign outV[0]  = ifA.out;
  assign outV[1]  = ifB.out;
  assign outV[2]  = ifC.out;
  assign outV[3]  = ifD.out;
  assign doneV[0] = ifA.done;
  assign doneV[1] = ifB.done;
  assign doneV[2] = ifC.done;
  assign doneV[3] = ifD.done;
  assign missV[0] = ifA.miss;
  assign missV[1] = ifB.miss;
  assign missV[2] = ifC.miss;
  assign missV[3] = ifD.miss;

  typedef struct packed {
    logic [NCH-1:0] out;
    logic [NCH-1:0] done;
    logic [NCH-1:0] miss;
  } exp_t;

  // Masks are indexed by cycle number; cycle 0 is the first cycle after
  // reset releases, and a mask bit c describes cycle c.
  typedef struct {
    string          name;
    int             cfg;
    logic [NCH-1:0] chMask;
    logic [LW-1:0]  lenA;
    logic [LW-1:0]  lenB;
    int             lenSwitch;
    logic [31:0]    inMask;
    logic [31:0]    enaOffMask;
    logic [31:0]    outMask;
    logic [31:0]    doneMask;
    logic [31:0]    missMask;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[NVEC];
  int   nCompared;
  int   nMismatched;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input string name, input int cfg, input logic [NCH-1:0] chMask,
                                 input logic [LW-1:0] lenA, input logic [LW-1:0] lenB,
                                 input int lenSwitch, input logic [31:0] inMask,
                                 input logic [31:0] enaOffMask, input logic [31:0] outMask,
                                 input logic [31:0] doneMask, input logic [31:0] missMask);
    vec_t v;
    v.name       = name;
    v.cfg        = cfg;
    v.chMask     = chMask;
    v.lenA       = lenA;
    v.lenB       = lenB;
    v.lenSwitch  = lenSwitch;
    v.inMask     = inMask;
    v.enaOffMask = enaOffMask;
    v.outMask    = outMask;
    v.doneMask   = doneMask;
    v.missMask   = missMask;
    return v;
  endfunction

  task automatic compareBits(input string name, input string field, input int cyc,
                             input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s.%s cycle %0d: got %b want %b", name, field, cyc, got, want);
    end
  endtask

  task automatic compareInt(input string name, input int got, input int want);
    nCompared++;
    if (got != want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic driveAll(input logic [NCH-1:0] inBits, input logic enaBit, input logic [LW-1:0] lenVal);
    ifA.in = inBits;  ifA.ena = enaBit;  ifA.len = {NCH{lenVal}};
    ifB.in = inBits;  ifB.ena = enaBit;  ifB.len = {NCH{lenVal}};
    ifC.in = inBits;  ifC.ena = enaBit;  ifC.len = {NCH{lenVal}};
    ifD.in = inBits;  ifD.ena = enaBit;  ifD.len = {NCH{lenVal}};
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] inBits, input logic enaBit,
                               input logic [LW-1:0] lenVal, input logic rstBit);
    @(negedge clk);
    rst = rstBit;
    driveAll(inBits, enaBit, lenVal);
  endtask

  task automatic checkOutput(input int cfg, input string name, input int cyc);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s cycle %0d: scoreboard empty", name, cyc);
    end else begin
      e = sbQ.pop_front();
      compareBits(name, "out",  cyc, outV[cfg],  e.out);
      compareBits(name, "done", cyc, doneV[cfg], e.done);
      compareBits(name, "miss", cyc, missV[cfg], e.miss);
    end
  endtask

  // One reset cycle; inHeld lets a sequence start with an input already high.
  task automatic doReset(input int cfg, input string name, input logic [NCH-1:0] inHeld);
    @(negedge clk);
    rst = 1'b1;
    driveAll(inHeld, 1'b1, '0);
    @(posedge clk);
    #1;
    compareBits(name, "resetOut",  -1, outV[cfg],  '0);
    compareBits(name, "resetDone", -1, doneV[cfg], '0);
    compareBits(name, "resetMiss", -1, missV[cfg], '0);
  endtask

  initial begin
    exp_t e;
    int   highCount;
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b1;
    driveAll('0, 1'b0, '0);

    //                name             cfg ch       lenA   lenB   sw inMask  enaOff  outMask   doneMask  missMask
    vecs[0]  = mkVec("basic",          0, 4'b0001, 8'd5,  8'd5,  0, 32'h4,   32'h0,  32'hF8,   32'h100,  32'h0);
    vecs[1]  = mkVec("retrig",         0, 4'b0001, 8'd4,  8'd4,  0, 32'h14,  32'h0,  32'h1F8,  32'h200,  32'h0);
    vecs[2]  = mkVec("noRetrig",       1, 4'b0001, 8'd4,  8'd4,  0, 32'h14,  32'h0,  32'h78,   32'h80,   32'h20);
    vecs[3]  = mkVec("reloadAtOne",    1, 4'b0001, 8'd4,  8'd4,  0, 32'h54,  32'h0,  32'h7F8,  32'h800,  32'h20);
    vecs[4]  = mkVec("edgeHeld",       0, 4'b0001, 8'd3,  8'd3,  0, 32'hFFC, 32'h0,  32'h38,   32'h40,   32'h0);
    vecs[5]  = mkVec("levelHeld",      2, 4'b0001, 8'd3,  8'd3,  0, 32'hFFC, 32'h0,  32'h7FF8, 32'h8000, 32'h0);
    vecs[6]  = mkVec("levelNoRetrig",  3, 4'b0001, 8'd3,  8'd3,  0, 32'hFFC, 32'h0,  32'h7FF8, 32'h8000, 32'hDB0);
    vecs[7]  = mkVec("lenZero",        1, 4'b0001, 8'd0,  8'd0,  0, 32'h54,  32'h0,  32'h0,    32'h0,    32'h0);
    vecs[8]  = mkVec("lenChange",      0, 4'b0001, 8'd5,  8'd2,  3, 32'h4,   32'h0,  32'hF8,   32'h100,  32'h0);
    vecs[9]  = mkVec("enaLow",         0, 4'b0001, 8'd5,  8'd5,  0, 32'h4,   32'h4,  32'h0,    32'h0,    32'h0);
    vecs[10] = mkVec("enaLowRunning",  0, 4'b0001, 8'd5,  8'd5,  0, 32'h4,   32'h78, 32'hF8,   32'h100,  32'h0);
    vecs[11] = mkVec("allChannels",    1, 4'b1111, 8'd3,  8'd3,  0, 32'h4,   32'h0,  32'h38,   32'h40,   32'h0);
    vecs[12] = mkVec("highAtReset",    0, 4'b0010, 8'd2,  8'd2,  0, 32'h3F,  32'h0,  32'h6,    32'h8,    32'h0);

    for (int v = 0; v < NVEC; v++) begin
      doReset(vecs[v].cfg, vecs[v].name, vecs[v].inMask[0] ? vecs[v].chMask : '0);
      for (int k = 0; k < NCYC; k++) begin
        e.out  = vecs[v].outMask[k+1]  ? vecs[v].chMask : '0;
        e.done = vecs[v].doneMask[k+1] ? vecs[v].chMask : '0;
        e.miss = vecs[v].missMask[k+1] ? vecs[v].chMask : '0;
        sbQ.push_back(e);
        applyStimulus(vecs[v].inMask[k] ? vecs[v].chMask : '0, ~vecs[v].enaOffMask[k],
                      (k >= vecs[v].lenSwitch) ? vecs[v].lenB : vecs[v].lenA, 1'b0);
        checkOutput(vecs[v].cfg, vecs[v].name, k + 1);
      end
    end

    // Longest stretch: trigger in cycle 2, high 3..257, done in 258.
    doReset(0, "maxLen", '0);
    highCount = 0;
    for (int k = 0; k < 300; k++) begin
      e.out  = (k + 1 >= 3 && k + 1 <= 257) ? 4'b0001 : 4'b0000;
      e.done = (k + 1 == 258) ? 4'b0001 : 4'b0000;
      e.miss = '0;
      sbQ.push_back(e);
      applyStimulus((k == 2) ? 4'b0001 : 4'b0000, 1'b1, MAX_LEN, 1'b0);
      checkOutput(0, "maxLen", k + 1);
      if (outV[0][0] === 1'b1) highCount++;
    end
    compareInt("maxLenHighCycles", highCount, 255);

    // Reset during a len=8 stretch started in cycle 2: rst sampled in cycle 4,
    // everything quiet from cycle 5 on with no late done.
    doReset(0, "midReset", '0);
    for (int k = 0; k < NCYC; k++) begin
      e.out  = (k + 1 == 3 || k + 1 == 4) ? 4'b0001 : 4'b0000;
      e.done = '0;
      e.miss = '0;
      sbQ.push_back(e);
      applyStimulus((k == 2) ? 4'b0001 : 4'b0000, 1'b1, 8'd8, (k == 4));
      checkOutput(0, "midReset", k + 1);
    end

    compareInt("scoreboardDrained", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
